// File: rtl/f_le_serial_responder.sv
// -----------------------------------------------------------------------------
// f_le_serial_responder
//
// Responder for the float less-or-equal interface. It accepts one request at a
// time and returns res = (a <= b) together with err for two FLEN-bit IEEE-754
// operands. The magnitude compare runs serially, CHUNK bits per cycle, starting
// at the MSB. The latency is fixed at FLEN/CHUNK + 1 cycles after acceptance.
//
// Ports
//   clk        in   1     clock, all state updates on posedge
//   rst        in   1     synchronous active-high reset
//   valid_in   in   1     request strobe, accepted only while busy == 0
//   a, b       in   FLEN  operands, sampled on acceptance
//   busy       out  1     high whenever the FSM is not IDLE
//   valid_out  out  1     one-cycle pulse, res/err belong to the last request
//   res        out  1     a <= b, forced 0 when err; held until the next result
//   err        out  1     either operand has an all-ones exponent; held
// -----------------------------------------------------------------------------
module f_le_serial_responder #(
    parameter int FLEN  = 64,
    parameter int CHUNK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            busy,
    output logic            valid_out,
    output logic            res,
    output logic            err
);

    localparam int N     = FLEN / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int EXP_W = (FLEN == 64) ? 11 : 8;

    generate
        if (FLEN % CHUNK != 0) begin : g_bad_chunk
            $error("f_le_serial_responder: FLEN must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [FLEN-1:0]    a_q, a_d;
    logic [FLEN-1:0]    b_q, b_d;
    logic               lt_q, lt_d;
    logic               gt_q, gt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_q, res_d;
    logic               err_q, err_d;

    // Magnitudes drop the sign bit; viewed as N chunks so the MSB chunk is N-1.
    logic [N-1:0][CHUNK-1:0] chunks_a, chunks_b;
    logic [CNT_W-1:0]        chunk_idx;
    logic [CHUNK-1:0]        chunk_a, chunk_b;
    logic                    sign_a, sign_b, zero_a, zero_b;

    assign chunks_a  = {1'b0, a_q[FLEN-2:0]};
    assign chunks_b  = {1'b0, b_q[FLEN-2:0]};
    assign chunk_idx = CNT_W'(N - 1) - cnt_q;
    assign chunk_a   = chunks_a[chunk_idx];
    assign chunk_b   = chunks_b[chunk_idx];
    assign sign_a    = a_q[FLEN-1];
    assign sign_b    = b_q[FLEN-1];
    assign zero_a    = (a_q[FLEN-2:0] == '0);
    assign zero_b    = (b_q[FLEN-2:0] == '0);

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    a_d     = a;
                    b_d     = b;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = CMP;
                end
            end

            CMP: begin
                // Only the first differing chunk from the MSB decides the order.
                if (!lt_q && !gt_q) begin
                    lt_d = (chunk_a < chunk_b);
                    gt_d = (chunk_a > chunk_b);
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    // The result is built from the final flags, so it is ready
                    // on the same edge that enters DONE.
                    err_d = (&a_q[FLEN-2 -: EXP_W]) | (&b_q[FLEN-2 -: EXP_W]);
                    if (err_d)                res_d = 1'b0;
                    else if (zero_a && zero_b) res_d = 1'b1;
                    else if (sign_a != sign_b) res_d = sign_a;
                    else if (!sign_a)          res_d = !gt_d;
                    else                       res_d = !lt_d;
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // Control state and visible results.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the values present before the edge, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            res_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // NOTE: operand, flag and counter registers carry no reset; they are
    // always loaded on acceptance before being read.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        lt_q  <= lt_d;
        gt_q  <= gt_d;
        cnt_q <= cnt_d;
    end

    assign busy      = (state_q != IDLE);
    assign valid_out = (state_q == DONE);
    assign res       = res_q;
    assign err       = err_q;

endmodule

// File: tb/tb_f_le_serial_responder.sv
// -----------------------------------------------------------------------------
// tb_f_le_serial_responder
//
// Self-checking bench for f_le_serial_responder (FLEN=64, CHUNK=16). The
// reference model compares the operands as real numbers, which orders +/-0 and
// subnormals naturally. The error flag comes from the exponent fields.
// -----------------------------------------------------------------------------
module tb_f_le_serial_responder;

    localparam int FLEN  = 64;
    localparam int CHUNK = 16;
    localparam int N     = FLEN / CHUNK;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in;
    logic [FLEN-1:0] a, b;
    logic            busy, valid_out, res, err;

    int vectors    = 0;
    int miscompares = 0;

    f_le_serial_responder #(.FLEN(FLEN), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .valid_out (valid_out),
        .res       (res),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: real-valued compare, err on any all-ones exponent.
    function automatic void model_le(input logic [63:0] x, input logic [63:0] y,
                                     output logic r, output logic e);
        e = (&x[62:52]) | (&y[62:52]);
        if (e) r = 1'b0;
        else   r = ($bitstoreal(x) <= $bitstoreal(y));
    endfunction

    // One request from an idle DUT: checks acceptance, busy profile, the
    // single valid_out pulse at t+N+1 and the returned result.
    task automatic run_req(input logic [63:0] x, input logic [63:0] y, input string tag);
        logic exp_r, exp_e;
        model_le(x, y, exp_r, exp_e);
        @(negedge clk);
        check({tag, "_idle"}, busy, 1'b0);
        valid_in = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        valid_in = 1'b0;
        a = $urandom();
        b = $urandom();
        for (int k = 1; k <= N + 1; k++) begin
            if (k > 1) @(negedge clk);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_vout"}, valid_out, (k == N + 1));
        end
        check({tag, "_res"}, res, exp_r);
        check({tag, "_err"}, err, exp_e);
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0: v[62:52] = 11'h7FF;                 // NaN / Inf
            1: v[62:0]  = '0;                      // signed zero
            2: v[62:52] = '0;                      // subnormal
            3: v[62:52] = 11'(1023 + $urandom_range(0, 3));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int acc_cyc[$];
        logic [63:0] x, y;

        rst      = 1'b1;
        valid_in = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_vout", valid_out, 1'b0);
        check("rst_res",  res, 1'b0);
        check("rst_err",  err, 1'b0);
        rst = 1'b0;

        // Directed cases.
        run_req(64'h3FF0000000000000, 64'h4000000000000000, "one_le_two");
        run_req(64'h4000000000000000, 64'h3FF0000000000000, "two_le_one");
        run_req(64'hC008000000000000, 64'hC008000000000000, "neg3_eq");
        run_req(64'hC008000000000000, 64'hBFF0000000000000, "neg3_le_neg1");
        run_req(64'h8000000000000000, 64'h0000000000000000, "nz_pz");
        run_req(64'h0000000000000000, 64'h8000000000000000, "pz_nz");
        run_req(64'h7FF8000000000000, 64'h3FF0000000000000, "nan");
        run_req(64'h3FF0000000000000, 64'hFFF0000000000000, "ninf");
        run_req(64'h0000000000000001, 64'h0000000000000002, "last_chunk");
        run_req(64'h0000000000000002, 64'h0000000000000001, "last_chunk_gt");

        // valid_in held high: acceptances every N+2 cycles.
        @(negedge clk);
        valid_in = 1'b1;
        a = 64'h3FF0000000000000;
        b = 64'h4000000000000000;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (!busy) acc_cyc.push_back(c);
            if (valid_out) check("hold_res", res, 1'b1);
        end
        valid_in = 1'b0;
        check("hold_count", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("hold_spacing", acc_cyc[i] - acc_cyc[i-1], N + 2);
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        check("hold_drain", busy, 1'b0);

        // Reset at t+2 aborts the request; a new one at t+4 completes at t+9.
        @(negedge clk);
        valid_in = 1'b1;
        a = 64'h4000000000000000;
        b = 64'h3FF0000000000000;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_vout", valid_out, 1'b0);
        check("abort_res",  res, 1'b0);
        check("abort_err",  err, 1'b0);
        run_req(64'h3FF0000000000000, 64'h4000000000000000, "after_abort");

        // Randomized requests, including equal and sign-flipped pairs.
        for (int i = 0; i < 300; i++) begin
            x = rand_operand();
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = {~x[63], x[62:0]};
                2: y = x + 64'($urandom_range(0, 2));
                default: y = rand_operand();
            endcase
            if ($urandom_range(0, 1) == 1) run_req(x, y, "rand");
            else                           run_req(y, x, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
